// File: rtl/prewish_pkg.sv
// Shared types and constants for the prewish mask scheduler and its prescaler.
package prewish_pkg;

  localparam int MASK_W = 8;
  localparam logic [MASK_W-1:0] DEFAULT_MASK = 8'hA8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/prewish_tick_gen.sv
// Free-running prescaler with enable and synchronous restart.
// tick is high for one cycle whenever the enabled counter is all ones.
module prewish_tick_gen #(
  parameter int W = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tick
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (restart) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + W'(1);
    end
  end

  assign tick = en && (&cnt_reg);

endmodule

// File: rtl/prewish_mask_sched.sv
// Mask scheduler: steps a mask table once per prescaler tick into the blinky load port.
// Define PREWISH_MASK_SCHED_OVERRIDE_EN to add the manual override ports and HOLD state.
module prewish_mask_sched
  import prewish_pkg::*;
#(
  parameter int                NEWMASK_CLK_BITS = 26,
  parameter int                DEPTH            = 4,
  parameter logic [MASK_W-1:0] DEFAULT_MASK     = prewish_pkg::DEFAULT_MASK,
  parameter int                HOLD_TICKS       = 2
) (
  input  logic                     CLK_I,
  input  logic                     RST_I,
  input  logic                     i_run,
  input  logic [$clog2(DEPTH):0]   i_len,
  input  logic                     i_cfg_we,
  input  logic [$clog2(DEPTH)-1:0] i_cfg_addr,
  input  logic [MASK_W-1:0]        i_cfg_data,
`ifdef PREWISH_MASK_SCHED_OVERRIDE_EN
  input  logic                     i_ovr_stb,
  input  logic [MASK_W-1:0]        i_ovr_data,
`endif
  output logic                     STB_O,
  output logic [MASK_W-1:0]        DAT_O,
  output logic [$clog2(DEPTH)-1:0] o_idx,
  output logic                     o_hold
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int LEN_W  = IDX_W + 1;
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1) + 1;

  logic              ovr_stb;
  logic [MASK_W-1:0] ovr_data;

`ifdef PREWISH_MASK_SCHED_OVERRIDE_EN
  assign ovr_stb  = i_ovr_stb;
  assign ovr_data = i_ovr_data;
`else
  assign ovr_stb  = 1'b0;
  assign ovr_data = '0;
`endif

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic              stb_reg, stb_next;
  logic [MASK_W-1:0] dat_reg, dat_next;
  logic [MASK_W-1:0] table_rd [DEPTH];

  logic [LEN_W-1:0]  eff_len;
  logic [IDX_W-1:0]  rd_idx, rd_idx_inc;
  logic              run_ok, tick, cnt_en, cnt_restart;

  // Table entries are plain registers so reset can restore every entry.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_table
      logic [MASK_W-1:0] entry_reg;

      always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
          entry_reg <= DEFAULT_MASK;
        end else if (i_cfg_we && (i_cfg_addr == IDX_W'(gi))) begin
          entry_reg <= i_cfg_data;
        end
      end

      assign table_rd[gi] = entry_reg;
    end
  endgenerate

  assign eff_len     = (i_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : i_len;
  assign run_ok      = i_run && (eff_len != '0);
  assign rd_idx      = ({1'b0, idx_reg} >= eff_len) ? '0 : idx_reg;
  assign rd_idx_inc  = (({1'b0, rd_idx} + LEN_W'(1)) == eff_len) ? '0 : rd_idx + IDX_W'(1);
  assign cnt_en      = (state_reg == RUN) || (state_reg == HOLD);
  assign cnt_restart = (state_reg == IDLE) && (state_next == RUN);

  prewish_tick_gen #(
    .W (NEWMASK_CLK_BITS)
  ) u_tick_gen (
    .clk     (CLK_I),
    .rst     (RST_I),
    .en      (cnt_en),
    .restart (cnt_restart),
    .tick    (tick)
  );

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    hold_cnt_next = hold_cnt_reg;
    stb_next      = 1'b0;
    dat_next      = dat_reg;

    // An override always wins the load port; a coincident tick is dropped.
    if (ovr_stb) begin
      stb_next      = 1'b1;
      dat_next      = ovr_data;
      hold_cnt_next = HOLD_W'(HOLD_TICKS);
    end

    case (state_reg)
      IDLE: begin
        if (!ovr_stb && run_ok) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (!run_ok) begin
          state_next = IDLE;
        end else if (ovr_stb) begin
          state_next = HOLD;
        end else if (tick) begin
          stb_next = 1'b1;
          dat_next = table_rd[rd_idx];
          idx_next = rd_idx_inc;
        end
      end
      HOLD: begin
        if (!i_run) begin
          state_next = IDLE;
        end else if (!ovr_stb && tick) begin
          if (hold_cnt_reg <= HOLD_W'(1)) begin
            state_next    = RUN;
            hold_cnt_next = '0;
          end else begin
            hold_cnt_next = hold_cnt_reg - HOLD_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      hold_cnt_reg <= '0;
      stb_reg      <= 1'b0;
      dat_reg      <= DEFAULT_MASK;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      hold_cnt_reg <= hold_cnt_next;
      stb_reg      <= stb_next;
      dat_reg      <= dat_next;
    end
  end

  assign STB_O = stb_reg;
  assign DAT_O = dat_reg;
  assign o_idx = idx_reg;

`ifdef PREWISH_MASK_SCHED_OVERRIDE_EN
  assign o_hold = (state_reg == HOLD);
`else
  assign o_hold = 1'b0;
`endif

endmodule
